// File: rtl/bus_pkt_endpoint.sv
// -----------------------------------------------------------------------------
// bus_pkt_endpoint
//
// Peripheral-side end of the 65-bit parallel bus packet interface. Pops
// packets from the node's bus-output FIFO, decodes them into a single
// request/ready handshake toward a register or peripheral core, and formats
// read responses that are pushed into the node's bus-input FIFO.
//
// Packet layout (BITS = 65):
//   [64:62] dest  [61:59] src  [58] wr (request) / err (response)
//   [57:32] addr  [31:0]  data
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   pndng_in   : bus-output FIFO not empty, head packet on D_pop
//   pop        : one-cycle pop strobe to the bus-output FIFO
//   D_pop      : head packet of the bus-output FIFO
//   push       : one-cycle push strobe to the bus-input FIFO
//   D_push     : response packet, valid while push = 1
//   req_valid  : request to the core, held until req_ready
//   req_ready  : core accepts the request
//   req_wr     : 1 = write, 0 = read
//   req_addr   : request address
//   req_wdata  : write data
//   req_src    : source node id of the request
//   rsp_valid  : read data valid from the core (sampled in WAIT_RSP only)
//   rsp_rdata  : read data from the core
//   busy       : endpoint is not idle
//   drop_cnt   : saturating count of discarded packets
//   tmo_cnt    : saturating count of read timeouts
//
// Every output is a flop; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module bus_pkt_endpoint #(
   parameter int          BITS     = 65,
   parameter logic [2:0]  MY_ID    = 3'd1,
   parameter logic [2:0]  BDCST    = 3'b111,
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF,
   parameter int          CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pndng_in,
   output logic             pop,
   input  logic [BITS-1:0]  D_pop,
   output logic             push,
   output logic [BITS-1:0]  D_push,
   output logic             req_valid,
   input  logic             req_ready,
   output logic             req_wr,
   output logic [25:0]      req_addr,
   output logic [31:0]      req_wdata,
   output logic [2:0]       req_src,
   input  logic             rsp_valid,
   input  logic [31:0]      rsp_rdata,
   output logic             busy,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] tmo_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POP      = 3'd1,
      S_DECODE   = 3'd2,
      S_REQ      = 3'd3,
      S_WAIT_RSP = 3'd4,
      S_PUSH     = 3'd5
   } state_t;

   // Last timer value spent in WAIT_RSP before giving up; the push then
   // lands exactly TIMEOUT cycles after WAIT_RSP was entered.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_pop;
   logic              r_push;
   logic [BITS-1:0]   r_d_push;
   logic              r_req_valid;
   logic              r_req_wr;
   logic [25:0]       r_req_addr;
   logic [31:0]       r_req_wdata;
   logic [2:0]        r_req_src;
   logic              r_req_bdcst;
   logic              r_busy;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic [CNT_W-1:0]  r_tmo_cnt;
   logic [7:0]        r_timer;
   logic [BITS-1:0]   r_hold;

   logic [2:0]        w_dest;
   logic [2:0]        w_src;
   logic              w_wr;
   logic [25:0]       w_addr;
   logic [31:0]       w_data;
   logic              w_for_me;

   // Saturating increment: status counters stick at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v)
         return v;
      else
         return v + CNT_W'(1);
   endfunction

   // Field split of the captured packet.
   assign w_dest   = r_hold[BITS-1 -: 3];
   assign w_src    = r_hold[BITS-4 -: 3];
   assign w_wr     = r_hold[BITS-7];
   assign w_addr   = r_hold[57:32];
   assign w_data   = r_hold[31:0];
   assign w_for_me = (w_dest == MY_ID) || (w_dest == BDCST);

   // Hold register: the FIFO head is still valid during the pop cycle and is
   // captured on the edge that retires it. Pure data, so it carries no reset.
   always_ff @(posedge clk) begin
      if (r_state == S_POP)
         r_hold <= D_pop;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_pop       <= 1'b0;
         r_push      <= 1'b0;
         r_d_push    <= '0;
         r_req_valid <= 1'b0;
         r_req_wr    <= 1'b0;
         r_req_addr  <= '0;
         r_req_wdata <= '0;
         r_req_src   <= '0;
         r_req_bdcst <= 1'b0;
         r_busy      <= 1'b0;
         r_drop_cnt  <= '0;
         r_tmo_cnt   <= '0;
         r_timer     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (pndng_in) begin
                  r_state <= S_POP;
                  r_pop   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end

            S_POP: begin
               r_pop   <= 1'b0;
               r_state <= S_DECODE;
            end

            S_DECODE: begin
               if (!w_for_me) begin
                  r_drop_cnt <= sat_inc(r_drop_cnt);
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_req_valid <= 1'b1;
                  r_req_wr    <= w_wr;
                  r_req_addr  <= w_addr;
                  r_req_wdata <= w_data;
                  r_req_src   <= w_src;
                  r_req_bdcst <= (w_dest == BDCST);
                  r_state     <= S_REQ;
               end
            end

            S_REQ: begin
               if (req_ready) begin
                  r_req_valid <= 1'b0;
                  if (r_req_wr) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else if (r_req_bdcst) begin
                     // Nobody can collect a broadcast read reply; discard it.
                     r_drop_cnt <= sat_inc(r_drop_cnt);
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_timer <= '0;
                     r_state <= S_WAIT_RSP;
                  end
               end
            end

            S_WAIT_RSP: begin
               // A response in the timeout cycle still wins over the error.
               if (rsp_valid) begin
                  r_d_push <= {r_req_src, MY_ID, 1'b0, r_req_addr, rsp_rdata};
                  r_push   <= 1'b1;
                  r_state  <= S_PUSH;
               end else if (r_timer == TMO_LAST) begin
                  r_d_push  <= {r_req_src, MY_ID, 1'b1, r_req_addr, ERR_DATA};
                  r_push    <= 1'b1;
                  r_tmo_cnt <= sat_inc(r_tmo_cnt);
                  r_state   <= S_PUSH;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end

            S_PUSH: begin
               r_push   <= 1'b0;
               r_d_push <= '0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end

            default: begin
               r_pop       <= 1'b0;
               r_push      <= 1'b0;
               r_req_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign pop       = r_pop;
   assign push      = r_push;
   assign D_push    = r_d_push;
   assign req_valid = r_req_valid;
   assign req_wr    = r_req_wr;
   assign req_addr  = r_req_addr;
   assign req_wdata = r_req_wdata;
   assign req_src   = r_req_src;
   assign busy      = r_busy;
   assign drop_cnt  = r_drop_cnt;
   assign tmo_cnt   = r_tmo_cnt;

endmodule

// File: tb/tb_bus_pkt_endpoint.sv
// -----------------------------------------------------------------------------
// tb_bus_pkt_endpoint
//
// Directed and randomized packet traffic into bus_pkt_endpoint. Expected
// behaviour comes from a packet-level reference model: each packet is
// classified from its dest/wr fields, and the expected request, response
// packet, push cycle and counter values are computed from those rules.
// -----------------------------------------------------------------------------
module tb_bus_pkt_endpoint;

   localparam logic [2:0] MY_ID    = 3'd1;
   localparam logic [2:0] BDCST    = 3'b111;
   localparam int         TIMEOUT  = 16;
   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pndng_in = 1'b0;
   logic        pop;
   logic [64:0] D_pop = '0;
   logic        push;
   logic [64:0] D_push;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_wr;
   logic [25:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_src;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_rdata = '0;
   logic        busy;
   logic [7:0]  drop_cnt;
   logic [7:0]  tmo_cnt;

   int checks = 0;
   int errors = 0;
   int exp_drop = 0;
   int exp_tmo = 0;

   bus_pkt_endpoint #(
      .BITS(65), .MY_ID(MY_ID), .BDCST(BDCST), .TIMEOUT(TIMEOUT),
      .ERR_DATA(ERR_DATA), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .pndng_in(pndng_in), .pop(pop), .D_pop(D_pop),
      .push(push), .D_push(D_push), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_src(req_src), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .busy(busy), .drop_cnt(drop_cnt), .tmo_cnt(tmo_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pop"},   65'(pop), 65'(0));
      chk({tag, "_push"},  65'(push), 65'(0));
      chk({tag, "_dpush"}, D_push, 65'(0));
      chk({tag, "_rv"},    65'(req_valid), 65'(0));
      chk({tag, "_rfld"},  65'({req_wr, req_addr, req_wdata, req_src}), 65'(0));
      chk({tag, "_busy"},  65'(busy), 65'(0));
      chk({tag, "_cnts"},  65'({drop_cnt, tmo_cnt}), 65'(0));
   endtask

   // One packet through the endpoint. Starts and ends with the DUT idle.
   // stall: cycles req_ready is held low; d: WAIT_RSP cycle index at which the
   // core answers (d >= TIMEOUT means it never answers).
   task automatic run_pkt(input logic [64:0] pkt, input int stall, input int d);
      logic [2:0]  dest;
      logic [2:0]  src;
      logic        wr;
      logic [25:0] addr;
      logic [31:0] data;
      logic [31:0] rdat;
      logic [64:0] exp_pkt;
      int          p;
      dest = pkt[64:62];
      src  = pkt[61:59];
      wr   = pkt[58];
      addr = pkt[57:32];
      data = pkt[31:0];

      pndng_in = 1'b1;
      D_pop    = pkt;
      step();
      chk("pop_latency", 65'(pop), 65'(1));
      chk("busy_on_pop", 65'(busy), 65'(1));
      pndng_in  = 1'b0;
      rsp_valid = 1'($urandom);
      step();
      chk("pop_one_cycle", 65'(pop), 65'(0));
      chk("rv_in_decode", 65'(req_valid), 65'(0));
      rsp_valid = 1'b0;
      step();
      if (dest != MY_ID && dest != BDCST) begin
         exp_drop = sat(exp_drop);
         chk("rv_misaddr", 65'(req_valid), 65'(0));
         chk("busy_misaddr", 65'(busy), 65'(0));
         chk("drop_misaddr", 65'(drop_cnt), 65'(exp_drop));
         return;
      end
      chk("req_valid", 65'(req_valid), 65'(1));
      chk("req_fields", 65'({req_wr, req_addr, req_wdata, req_src}),
          65'({wr, addr, data, src}));
      for (int k = 0; k < stall; k++) begin
         rsp_valid = 1'($urandom);
         step();
         chk("rv_stall", 65'(req_valid), 65'(1));
         chk("fields_stall", 65'({req_wr, req_addr, req_wdata, req_src}),
             65'({wr, addr, data, src}));
      end
      rsp_valid = 1'b0;
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      chk("rv_after_hs", 65'(req_valid), 65'(0));
      if (wr) begin
         chk("busy_after_wr", 65'(busy), 65'(0));
         chk("push_after_wr", 65'(push), 65'(0));
         step();
         chk("push_after_wr2", 65'(push), 65'(0));
         return;
      end
      if (dest == BDCST) begin
         exp_drop = sat(exp_drop);
         chk("busy_bc_rd", 65'(busy), 65'(0));
         chk("drop_bc_rd", 65'(drop_cnt), 65'(exp_drop));
         step();
         chk("push_bc_rd", 65'(push), 65'(0));
         return;
      end
      rdat = $urandom;
      if (d < TIMEOUT) begin
         p = d + 1;
         exp_pkt = {src, MY_ID, 1'b0, addr, rdat};
      end else begin
         p = TIMEOUT;
         exp_tmo = sat(exp_tmo);
         exp_pkt = {src, MY_ID, 1'b1, addr, ERR_DATA};
      end
      for (int i = 0; i < p; i++) begin
         chk("push_early", 65'(push), 65'(0));
         chk("busy_wait", 65'(busy), 65'(1));
         rsp_valid = (i == d);
         rsp_rdata = (i == d) ? rdat : $urandom;
         step();
      end
      rsp_valid = 1'b0;
      chk("push_cycle", 65'(push), 65'(1));
      chk("d_push", D_push, exp_pkt);
      chk("tmo_cnt", 65'(tmo_cnt), 65'(exp_tmo));
      step();
      chk("push_one_cycle", 65'(push), 65'(0));
      chk("busy_after_push", 65'(busy), 65'(0));
   endtask

   initial begin
      logic [64:0] bpk [3];
      logic [64:0] pkt;
      logic [2:0]  dst;
      int          sel;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("rst");
      reset = 1'b1;
      step();
      chk_all_zero("post_rst");

      // Directed cases
      run_pkt({3'd1, 3'd0, 1'b1, 26'h0000ABC, 32'h1234_5678}, 0, 0);
      run_pkt({3'd1, 3'd2, 1'b0, 26'h0000010, 32'h0}, 1, 3);
      run_pkt({3'd3, 3'd5, 1'b1, 26'h0000123, 32'hDEAD_BEEF}, 0, 0);
      run_pkt({3'd7, 3'd4, 1'b1, 26'h0000200, 32'h0BAD_F00D}, 2, 0);
      run_pkt({3'd7, 3'd6, 1'b0, 26'h0000300, 32'h0}, 0, 0);
      run_pkt({3'd1, 3'd3, 1'b0, 26'h0000044, 32'h0}, 0, 1000);
      run_pkt({3'd1, 3'd5, 1'b0, 26'h0000048, 32'h0}, 0, TIMEOUT - 1);
      run_pkt({3'd1, 3'd6, 1'b0, 26'h000004C, 32'h0}, 0, 0);

      // Back-to-back writes with req_ready tied high: one packet per 4 cycles
      bpk[0] = {3'd1, 3'd2, 1'b1, 26'h1000001, 32'hA0A0_0001};
      bpk[1] = {3'd1, 3'd3, 1'b1, 26'h1000002, 32'hA0A0_0002};
      bpk[2] = {3'd7, 3'd4, 1'b1, 26'h1000003, 32'hA0A0_0003};
      req_ready = 1'b1;
      pndng_in  = 1'b1;
      D_pop     = bpk[0];
      for (int c = 1; c <= 13; c++) begin
         step();
         chk("b2b_pop", 65'(pop), 65'(c == 1 || c == 5 || c == 9));
         chk("b2b_rv", 65'(req_valid), 65'(c == 3 || c == 7 || c == 11));
         if (c == 3 || c == 7 || c == 11)
            chk("b2b_wdata", 65'(req_wdata), 65'(bpk[(c - 3) / 4][31:0]));
         if (c == 2 || c == 6) D_pop = bpk[(c + 2) / 4];
         if (c == 10) pndng_in = 1'b0;
      end
      req_ready = 1'b0;
      chk("b2b_push", 65'(push), 65'(0));

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         dst = (sel < 2) ? MY_ID : (sel == 2) ? BDCST : 3'($urandom);
         pkt = {dst, 3'($urandom), 1'($urandom), 26'($urandom), 32'($urandom)};
         run_pkt(pkt, $urandom_range(0, 3), $urandom_range(0, 20));
      end

      // Drop counter saturation
      for (int n = 0; n < 300; n++) begin
         dst = 3'($urandom_range(2, 6));
         run_pkt({dst, 3'($urandom), 1'($urandom), 26'($urandom), 32'($urandom)}, 0, 0);
      end
      chk("drop_saturated", 65'(drop_cnt), 65'(8'hFF));

      // Reset while in WAIT_RSP
      pndng_in = 1'b1;
      D_pop    = {3'd1, 3'd2, 1'b0, 26'h0000777, 32'h0};
      step();
      pndng_in = 1'b0;
      step();
      step();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      step();
      step();
      chk("wait_busy", 65'(busy), 65'(1));
      #2 reset = 1'b0;
      #1;
      chk_all_zero("rst_wait");
      exp_drop = 0;
      exp_tmo  = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("no_push_after_rst", 65'(push), 65'(0));
      end

      // Reset while in REQ, with a FIFO entry pending through reset
      pndng_in = 1'b1;
      D_pop    = {3'd1, 3'd4, 1'b0, 26'h0000999, 32'h0};
      step();
      pndng_in = 1'b0;
      step();
      step();
      chk("req_before_rst", 65'(req_valid), 65'(1));
      #2 reset = 1'b0;
      pndng_in = 1'b1;
      #1;
      chk_all_zero("rst_req");
      repeat (2) @(posedge clk);
      #1;
      chk("pop_in_rst", 65'(pop), 65'(0));
      reset = 1'b1;
      run_pkt({3'd1, 3'd5, 1'b1, 26'h0000555, 32'h5555_AAAA}, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_push", 65'(push), 65'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_pkt_endpoint.md
Name: bus_pkt_endpoint

Overview:
Peripheral-side end of the 65-bit parallel bus packet interface. Drains packets from a node's bus-output FIFO (pop side), decodes them into a simple request handshake toward a register/peripheral core, and formats read responses pushed into the node's bus-input FIFO (push side). One instance sits between each peripheral (spi, uart, ...) and its bus FIFO pair.

Parameters:
BITS, 65, packet width; the field layout below requires 65.
MY_ID, 1, 3-bit node id of this endpoint.
BDCST, 3'b111, broadcast destination id.
TIMEOUT, 16, cycles allowed in WAIT_RSP before an error response is sent; range 1..255.
ERR_DATA, 32'hFFFF_FFFF, data field of a timeout response.
CNT_W, 8, width of the status counters.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
pndng_in  in  1  bus-output FIFO not empty; its head is on D_pop
pop  out  1  one-cycle pop strobe to the bus-output FIFO
D_pop  in  BITS  head packet of the bus-output FIFO
push  out  1  one-cycle push strobe to the bus-input FIFO
D_push  out  BITS  response packet, valid while push=1
req_valid  out  1  request to the core
req_ready  in  1  core accepts the request
req_wr  out  1  1 = write, 0 = read
req_addr  out  26  request address
req_wdata  out  32  write data
req_src  out  3  source id of the request
rsp_valid  in  1  read data valid from the core
rsp_rdata  in  32  read data
busy  out  1  state != IDLE
drop_cnt  out  CNT_W  saturating count of discarded packets
tmo_cnt  out  CNT_W  saturating count of timeouts

Behaviour:
- Packet format: [64:62] dest, [61:59] src, [58] wr (request) or err (response), [57:32] addr, [31:0] data.
- Reset (reset=0, async): state IDLE. All outputs 0: pop, push, D_push, req_*, busy, drop_cnt, tmo_cnt. An in-flight transaction is abandoned with no partial push. Nothing is driven until the first rising edge after release.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- IDLE: if pndng_in=1, go to POP.
- POP: pop=1 for exactly one cycle. D_pop is captured into the hold register on this edge. Go to DECODE.
- DECODE (one cycle):
  - dest not MY_ID and not BDCST: increment drop_cnt, go to IDLE.
  - Otherwise load the req_* fields from the hold register and go to REQ.
- REQ: req_valid=1 with fields stable until the cycle where req_ready=1 (handshake).
  - After a write: go to IDLE.
  - After a read with dest=BDCST: increment drop_cnt, go to IDLE. No response is sent.
  - After any other read: clear the timer, go to WAIT_RSP.
  - req_valid deasserts in the cycle after the handshake.
- WAIT_RSP: the timer increments each cycle.
  - rsp_valid=1: latch rsp_rdata with err=0, go to PUSH.
  - Otherwise, when the timer reaches TIMEOUT-1: latch ERR_DATA with err=1, increment tmo_cnt, go to PUSH.
  - If rsp_valid and the timeout occur in the same cycle, the response wins.
- PUSH: push=1 for one cycle. D_push = {req_src, MY_ID, err, req_addr, data}. Go to IDLE.
- The push side has no backpressure; sizing the bus-input FIFO to absorb pushes is the system's responsibility.
- rsp_valid is ignored outside WAIT_RSP. pndng_in is ignored outside IDLE.
- Latency:
  - pndng_in=1 in IDLE to pop: 1 cycle.
  - pop to req_valid: 2 cycles.
  - rsp_valid to push: 1 cycle.
  - Back-to-back writes with req_ready tied 1: one packet per 4 cycles.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Write to MY_ID=1: D_pop={3'd1,3'd0,1'b1,26'h0000ABC,32'h1234_5678}, pndng_in=1, req_ready=1 -> pop 1 cycle after pndng_in; req_valid 2 cycles later with req_wr=1, addr 26'hABC, wdata 32'h12345678, src 0; no push; busy falls after 4 cycles.
- Read with response: dest=1, src=2, wr=0, addr 26'h10; core returns rsp_rdata=32'hCAFE_0001 3 cycles after the handshake -> push 1 cycle later with D_push={3'd2,3'd1,1'b0,26'h10,32'hCAFE0001}.
- Misaddressed packet, dest=3 -> pop asserted, no req_valid, drop_cnt 0->1, back to IDLE. 300 misaddressed packets -> drop_cnt saturates at 8'hFF.
- Broadcast: write dest=7 -> request issued, no push. Read dest=7 -> request issued, no push, drop_cnt +1.
- Timeout with TIMEOUT=16, read and rsp_valid never asserted -> push exactly 16 cycles after entering WAIT_RSP with err=1, data 32'hFFFFFFFF, tmo_cnt=1. A repeat run with rsp_valid in the 16th cycle -> err=0 with the core's data.
- Reset mid-operation: assert reset in WAIT_RSP and in REQ -> outputs go to 0 immediately without waiting for clk; no push after release; a pending FIFO entry is then popped normally.
